// File: rtl/spi_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_pkg
// Shared constants for the SPI frame receiver: frame geometry, field bit
// positions, the default address limit and the receiver FSM state encodings.
// Imported by spi_frame_receiver. The default address limit is only consulted
// when SPI_FRAME_ADDR_FILTER_EN is defined.
// -----------------------------------------------------------------------------
package spi_frame_pkg;

    // Frame geometry: 1 R/W bit + 7 address bits + 8 data bits.
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    // Wide enough to hold FRAME_BITS+1, the saturation value of the bit count.
    localparam int CNT_W      = 5;

    // Highest register address accepted when address filtering is enabled.
    localparam logic [ADDR_W-1:0] DEFAULT_MAX_ADDR = 7'h04;

    // Field positions inside the received frame (MSB is the first bit on the wire).
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Receiver FSM states, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t WAIT_IDLE = 2'd0;
    localparam state_t IDLE      = 2'd1;
    localparam state_t SHIFT     = 2'd2;

endpackage

// File: rtl/spi_frame_receiver_sync.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Multi-flop synchronizer for one asynchronous pin, followed by a single
// history flop used to detect edges on the synchronized level.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops (2 or 3)
//   RESET_VAL    value loaded into every flop on reset (the pin's idle level)
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   pin_in       raw asynchronous pin
//   level        synchronized pin level
//   rise         one-cycle strobe on a 0->1 transition of level
//   fall         one-cycle strobe on a 1->0 transition of level
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // Resetting the history flop to the same idle value as the chain means no
    // spurious edge is reported while the chain flushes after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_d <= RESET_VAL;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
// Synchronizes the raw SPI pins into the clk domain and deserializes 16-bit
// mode-0 frames (MSB first). Each chip-select window yields either one
// frame_valid strobe with the decoded frame, or one frame_error strobe when
// the window did not contain exactly FRAME_BITS clock rises.
//
// Optional feature (macro SPI_FRAME_ADDR_FILTER_EN): when defined, complete
// frames whose address exceeds MAX_ADDR are dropped with no strobe at all.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sclk         raw SPI clock pin
//   copi         raw SPI data-in pin
//   ncs          raw active-low chip select
//   frame_valid  one-cycle strobe, new frame on frame_* outputs
//   frame_write  R/W bit of the last valid frame (1 = write)
//   frame_addr   address field of the last valid frame
//   frame_data   data field of the last valid frame
//   frame_error  one-cycle strobe, malformed frame discarded
// -----------------------------------------------------------------------------
module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    // The field layout is fixed; this only documents the expected frame length.
    parameter int FRAME_BITS  = spi_frame_pkg::FRAME_BITS
`ifdef SPI_FRAME_ADDR_FILTER_EN
    ,
    parameter logic [spi_frame_pkg::ADDR_W-1:0] MAX_ADDR = spi_frame_pkg::DEFAULT_MAX_ADDR
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sclk,
    input  logic                             copi,
    input  logic                             ncs,
    output logic                             frame_valid,
    output logic                             frame_write,
    output logic [spi_frame_pkg::ADDR_W-1:0] frame_addr,
    output logic [spi_frame_pkg::DATA_W-1:0] frame_data,
    output logic                             frame_error
);

    import spi_frame_pkg::*;

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ncs_level, ncs_rise, ncs_fall;
    logic copi_level, copi_rise, copi_fall;
    logic edges_unused;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    addr_ok;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (sclk),
        .level  (sclk_level),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (ncs),
        .level  (ncs_level),
        .rise   (ncs_rise),
        .fall   (ncs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (copi),
        .level  (copi_level),
        .rise   (copi_rise),
        .fall   (copi_fall)
    );

    // Only the sclk rise and the copi level are needed by the receiver.
    assign edges_unused = sclk_level | sclk_fall | copi_rise | copi_fall;

    // Address check applied to a complete frame before it is forwarded.
`ifdef SPI_FRAME_ADDR_FILTER_EN
    assign addr_ok = (shift_reg[ADDR_MSB:ADDR_LSB] <= MAX_ADDR);
`else
    assign addr_ok = 1'b1;
`endif

    // Receiver FSM.
    // WAIT_IDLE: the ncs synchronizer resets to the idle (high) level, so its
    // first SYNC_STAGES samples after reset say nothing about the pin. The bit
    // counter doubles as a settle counter here: only SYNC_STAGES+1 consecutive
    // high samples prove the select is genuinely released, which guarantees a
    // select already low at reset release is never mistaken for a new frame.
    // SHIFT: an ncs rise takes priority over an sclk rise in the same cycle,
    // and evaluation happens on that same edge so the registered strobe
    // appears one cycle after the rise is detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            frame_write <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    if (ncs_level) begin
                        if (bit_cnt == CNT_SETTLE) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (ncs_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state <= IDLE;
                        if (bit_cnt == CNT_FULL) begin
                            if (addr_ok) begin
                                frame_valid <= 1'b1;
                                frame_write <= shift_reg[RW_BIT];
                                frame_addr  <= shift_reg[ADDR_MSB:ADDR_LSB];
                                frame_data  <= shift_reg[DATA_MSB:DATA_LSB];
                            end
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        if (bit_cnt < CNT_FULL) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
                        end
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
// Directed testbench for spi_frame_receiver. Drives SPI mode-0 frames through
// the raw pins with wide sclk phases and compares strobe counts and frame
// outputs against hand-computed values. With SPI_FRAME_ADDR_FILTER_EN defined
// the filter scenario expects out-of-range frames to be dropped.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       frame_valid;
    logic       frame_write;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_error;

    int checks = 0;
    int errors = 0;

    // Running strobe statistics gathered by the monitor below.
    int         valid_total = 0;
    int         error_total = 0;
    int         long_pulses = 0;
    logic       prev_valid = 1'b0;
    logic       prev_error = 1'b0;
    logic [7:0] last_valid_data = 8'h00;
    logic [7:0] prior_valid_data = 8'h00;

    spi_frame_receiver #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .copi        (copi),
        .ncs         (ncs),
        .frame_valid (frame_valid),
        .frame_write (frame_write),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // Outputs change on posedge; sample them on negedge.
    always @(negedge clk) begin
        if (frame_valid) begin
            valid_total++;
            prior_valid_data = last_valid_data;
            last_valid_data  = frame_data;
        end
        if (frame_error) error_total++;
        if ((frame_valid && prev_valid) || (frame_error && prev_error)) long_pulses++;
        prev_valid = frame_valid;
        prev_error = frame_error;
    end

    // Drives one chip-select window carrying nbits bits of value, MSB first.
    task automatic send_frame(input logic [31:0] value, input int nbits, input int pre_idle);
        repeat (pre_idle) @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = value[i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        ncs = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({frame_valid, frame_error, frame_write, frame_addr, frame_data} !== 17'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 00000",
                     {frame_valid, frame_error, frame_write, frame_addr, frame_data});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({frame_valid, frame_error, frame_write, frame_addr, frame_data} !== 17'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_outputs got %h want 00000",
                     {frame_valid, frame_error, frame_write, frame_addr, frame_data});
        end
    endtask

    // Full frame expected to be forwarded; checks strobes and decoded fields.
    task automatic test_valid_frame(input string name, input logic [15:0] value,
                                    input logic exp_w, input logic [6:0] exp_a, input logic [7:0] exp_d);
        int v0, e0;
        v0 = valid_total;
        e0 = error_total;
        send_frame({16'h0, value}, 16, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (valid_total - v0 !== 1) begin
            errors++;
            $display("[TB] FAIL %s_valid_count got %0d want 1", name, valid_total - v0);
        end
        checks++;
        if (error_total - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL %s_error_count got %0d want 0", name, error_total - e0);
        end
        checks++;
        if ({frame_write, frame_addr, frame_data} !== {exp_w, exp_a, exp_d}) begin
            errors++;
            $display("[TB] FAIL %s_fields got w=%0b a=%h d=%h want w=%0b a=%h d=%h",
                     name, frame_write, frame_addr, frame_data, exp_w, exp_a, exp_d);
        end
    endtask

    task automatic test_write_read;
        test_valid_frame("write", 16'h8480, 1'b1, 7'h04, 8'h80);
        test_valid_frame("read", 16'h02A5, 1'b0, 7'h02, 8'hA5);
    endtask

    task automatic test_bad_length;
        int v0, e0;
        v0 = valid_total;
        e0 = error_total;
        send_frame(32'h0000_7ABC, 15, 10);
        repeat (10) @(negedge clk);
        send_frame(32'h0001_5A5A, 17, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (error_total - e0 !== 2) begin
            errors++;
            $display("[TB] FAIL badlen_error_count got %0d want 2", error_total - e0);
        end
        checks++;
        if (valid_total - v0 !== 0) begin
            errors++;
            $display("[TB] FAIL badlen_valid_count got %0d want 0", valid_total - v0);
        end
        checks++;
        if ({frame_write, frame_addr, frame_data} !== {1'b0, 7'h02, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL badlen_hold got w=%0b a=%h d=%h want w=0 a=02 d=a5",
                     frame_write, frame_addr, frame_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        v0 = valid_total;
        e0 = error_total;
        // Nine bits of a frame, then reset while the select stays low.
        repeat (10) @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            copi = i[0];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({frame_write, frame_addr, frame_data} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL midreset_cleared got w=%0b a=%h d=%h want 0/00/00",
                     frame_write, frame_addr, frame_data);
        end
        // Full frame inside a select that was already low at reset release.
        for (int i = 15; i >= 0; i--) begin
            copi = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ((valid_total - v0) + (error_total - e0) !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_strobes got %0d want 0", (valid_total - v0) + (error_total - e0));
        end
        test_valid_frame("after_reset", 16'h8111, 1'b1, 7'h01, 8'h11);
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = valid_total;
        e0 = error_total;
        // Idle sclk activity before the first select.
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 0;
            repeat (4) @(negedge clk);
        end
        send_frame(32'h0000_8001, 16, 6);
        // SYNC_STAGES+2 clocks of ncs high, with one idle sclk pulse inside.
        @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        sclk = 1'b0;
        send_frame(32'h0000_8002, 16, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (valid_total - v0 !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_valid_count got %0d want 2", valid_total - v0);
        end
        checks++;
        if (error_total - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_error_count got %0d want 0", error_total - e0);
        end
        checks++;
        if ({prior_valid_data, last_valid_data} !== 16'h0102) begin
            errors++;
            $display("[TB] FAIL b2b_data_order got %h %h want 01 02", prior_valid_data, last_valid_data);
        end
        checks++;
        if ({frame_write, frame_addr, frame_data} !== {1'b1, 7'h00, 8'h02}) begin
            errors++;
            $display("[TB] FAIL b2b_fields got w=%0b a=%h d=%h want w=1 a=00 d=02",
                     frame_write, frame_addr, frame_data);
        end
    endtask

    task automatic test_addr_filter;
`ifdef SPI_FRAME_ADDR_FILTER_EN
        int v0, e0;
        v0 = valid_total;
        e0 = error_total;
        send_frame(32'h0000_8A55, 16, 10);
        repeat (10) @(negedge clk);
        checks++;
        if ((valid_total - v0) + (error_total - e0) !== 0) begin
            errors++;
            $display("[TB] FAIL filter_drop_strobes got %0d want 0", (valid_total - v0) + (error_total - e0));
        end
        checks++;
        if ({frame_write, frame_addr, frame_data} !== {1'b1, 7'h00, 8'h02}) begin
            errors++;
            $display("[TB] FAIL filter_drop_hold got w=%0b a=%h d=%h want w=1 a=00 d=02",
                     frame_write, frame_addr, frame_data);
        end
`else
        test_valid_frame("nofilter_high_addr", 16'h8A55, 1'b1, 7'h0A, 8'h55);
`endif
        test_valid_frame("max_addr", 16'h8455, 1'b1, 7'h04, 8'h55);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_bad_length;
        test_reset_mid_frame;
        test_back_to_back;
        test_addr_filter;
        checks++;
        if (long_pulses !== 0) begin
            errors++;
            $display("[TB] FAIL strobe_width got %0d long pulses want 0", long_pulses);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Front end of the SPI register path, directly upstream of the register-file/peripheral stage that drives the PWM block.
- Synchronizes raw sclk/copi/ncs pins into the system clock domain and deserializes 16-bit SPI mode-0 frames, MSB first.
- Emits one registered, validated frame per chip-select window: R/W bit, 7-bit address, 8-bit data.
- Pulses a single-cycle strobe that the register stage consumes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each pin synchronizer (legal: 2 or 3).
- FRAME_BITS, 16, bits per valid frame (fixed layout: 1 R/W + 7 addr + 8 data).
- MAX_ADDR, 7'h04, highest accepted address; used only with SPI_FRAME_ADDR_FILTER_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  raw SPI clock pin
- copi  input  1  raw SPI data-in pin
- ncs  input  1  raw active-low chip select
- frame_valid  output  1  one-cycle strobe: new frame on frame_* outputs
- frame_write  output  1  bit 15 of the frame (1 = write)
- frame_addr  output  7  bits 14:8 of the frame
- frame_data  output  8  bits 7:0 of the frame
- frame_error  output  1  one-cycle strobe: malformed frame discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - All outputs 0.
  - Synchronizers: ncs stages to 1, sclk and copi stages to 0.
  - Shift register 0, bit counter 0, state WAIT_IDLE.
- Synchronization: sclk, ncs and copi each pass through SYNC_STAGES flops. Edge detect compares the last sync stage with one extra flop. Synced copi is sampled in the same cycle the synced sclk rise is detected.
- Timing requirement: sclk high and low phases each at least SYNC_STAGES+1 clk cycles.
- States:
  - WAIT_IDLE: wait for synced ncs=1, then go to IDLE. A select that was already low at reset release is ignored.
  - IDLE: on synced ncs fall, clear shift register and counter, go to SHIFT.
  - SHIFT:
    - On each sclk rise, shift in copi (MSB first) if count<FRAME_BITS.
    - The counter increments and saturates at FRAME_BITS+1.
    - On synced ncs rise, go to IDLE and evaluate the frame.
- Evaluation (registered, one clk after the ncs rise is detected):
  - If count==FRAME_BITS: load frame_write, frame_addr and frame_data, and pulse frame_valid for 1 cycle.
  - Otherwise (short or long frame): pulse frame_error for 1 cycle. frame_* keep their previous values.
- Hold: frame_* hold their last valid frame until the next valid frame.
- Latency: ncs pin rise to frame_valid is SYNC_STAGES+2 clk cycles, ±1 for pin phase.
- Ignored input: sclk edges while not in SHIFT. A ncs glitch shorter than SYNC_STAGES cycles may be lost; no requirement applies.
- Simultaneous sclk rise and ncs rise in the same clk: the ncs rise wins and that bit is not shifted.
- Back-to-back frames: a new ncs fall is accepted in the cycle after evaluation. frame_valid never lasts more than 1 cycle.
- Reset mid-frame: partial data is discarded with no strobe. The block returns to WAIT_IDLE.

Optional Feature:
- Macro: SPI_FRAME_ADDR_FILTER_EN.
- Defined: a 16-bit frame with frame_addr > MAX_ADDR is dropped silently. No valid strobe, no error strobe, outputs unchanged.
- Undefined: every 16-bit frame is forwarded regardless of address, and MAX_ADDR is unused.

Decomposition:
- Package spi_frame_pkg:
  - Constants FRAME_BITS=16, ADDR_W=7, DATA_W=8, CNT_W=5.
  - Default MAX_ADDR.
  - State enum {WAIT_IDLE, IDLE, SHIFT}.
  - Bit-position constants for the R/W, addr and data fields.
- Sub-module sync_edge_detect:
  - Parameters SYNC_STAGES and RESET_VAL.
  - Outputs the synced level plus rise and fall strobes.
  - Instantiated for sclk, ncs and copi (level only for copi).

Test Plan:
- Write frame 0x8480 (write, addr 0x04, data 0x80) -> single frame_valid; frame_write=1, frame_addr=0x04, frame_data=0x80; frame_error stays 0.
- Read frame 0x02A5 after the write -> frame_valid; frame_write=0, frame_addr=0x02, frame_data=0xA5.
- 15-bit frame, then 17-bit frame -> frame_error pulses twice, no frame_valid; outputs still 0/0x02/0xA5.
- Reset asserted after 9 bits, released, then ncs held low at release followed by a full frame -> no strobes until ncs goes high. A subsequent frame 0x8111 gives frame_valid with addr 0x01, data 0x11.
- Two back-to-back frames 0x8001, 0x8002 with ncs high for SYNC_STAGES+2 clk, plus sclk edges toggled while ncs high -> exactly two frame_valid pulses with data 0x01 then 0x02; the idle sclk edges have no effect.
- With SPI_FRAME_ADDR_FILTER_EN, frame 0x8A55 (addr 0x0A) -> no strobes and outputs unchanged; frame 0x8455 -> frame_valid with addr 0x04, data 0x55.
